out_port_buffer: RTL and testbench
==================================

# out_port_buffer

Write-side buffer behind the CPU output port. Captures each 32-bit word the datapath emits on an `out` instruction (OutPort_In strobe with the value on the bus) and holds it in a small FIFO. Presents it to an external device through a valid/ready handshake. The CPU never stalls on a slow device; words are queued up to DEPTH and later writes are dropped and flagged.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- WIDTH, 32, data width; matches the datapath bus
- clock  in  1  single clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- OutPort_In  in  1  write strobe from the datapath control, one word per high cycle
- BusMuxOut  in  WIDTH  datapath bus value captured when OutPort_In is high
- OutPortData  out  WIDTH  head-of-queue word to the device
- out_valid  out  1  OutPortData holds a valid word
- out_ready  in  1  device accepts the head word this cycle
- out_count  out  $clog2(DEPTH)+1  current occupancy
- out_full  out  1  occupancy == DEPTH
- out_overflow  out  1  sticky: a write was dropped since the last clear

## Operation
- Occupancy FSM: EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count == DEPTH). State is derived from a registered count; no separate encoding.
- Write accepted at a rising edge when OutPort_In=1 and (not FULL, or a pop occurs the same edge). Stores BusMuxOut at wr_ptr, then wr_ptr+1.
- Pop at a rising edge when out_valid=1 and out_ready=1, then rd_ptr+1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is the only full/empty discriminator.
- Simultaneous push+pop: count unchanged. In FULL the write is accepted because the slot is freed the same edge. In EMPTY, push only; out_valid is 0, so no pop.
- Write in FULL without a pop: word is discarded, count unchanged, out_overflow set to 1. It stays 1 until clear.
- No bypass: a word written into EMPTY is not visible in the same cycle.
- OutPortData = entry at rd_ptr when out_valid=1, else 0. It stays stable while out_valid=1 and out_ready=0.
- out_ready while EMPTY is ignored.
- clear has priority over every other input, including mid-handshake. Pointers, count, out_valid, out_full, out_overflow and OutPortData all go to 0. Storage contents become don't-care; the pending word is lost, not delivered.

## Timing
- Reset values: OutPortData=0, out_valid=0, out_count=0, out_full=0, out_overflow=0, effective the edge after clear is sampled high.
- Write latency: strobe at edge n gives out_valid=1 and OutPortData=word after edge n.
- Throughput: one push and one pop per cycle sustained.
- out_full and out_count are registered and update after the edge that changes occupancy.
- out_overflow rises after the edge of the dropped write.

## Configuration
- OUT_PORT_LAST_EN defined: adds output `out_last [WIDTH-1:0]`.
  - Holds the most recent accepted write, 0 after clear.
  - Updated on every accepted push, including pushes into FULL with a simultaneous pop.
  - Unaffected by pops; supports the legacy single-register debug view.
- Undefined: port absent, no extra register.

## Structure
- Shared package `cpu_io_pkg`:
  - WORD_W=32 constant
  - default OUT_BUF_DEPTH=4
  - `occ_state_t` enum (EMPTY, PARTIAL, FULL), used by both this block and the future input-port buffer
- One sub-module, `io_fifo_mem`: a DEPTH×WIDTH register array with write enable/address and combinational read address. The top holds pointers, count, flags and handshake.

## Test plan
- clear, then OutPort_In=1 with BusMuxOut=32'h56781234 for one cycle, out_ready=0:
  - next cycle out_valid=1, OutPortData=32'h56781234, out_count=1
  - holds indefinitely
- Push 32'h11, 32'h22, 32'h33, 32'h44 with out_ready=0: out_full=1, out_count=4. Push 32'h55: out_overflow=1, count stays 4. Drain with out_ready=1: words out in order 11, 22, 33, 44, then out_valid=0.
- FULL with out_ready=1 and OutPort_In=1 (32'hAA) the same edge: count stays 4, head advances. 32'hAA is delivered fifth.
- Continuous push of 32'h1..32'h9 with out_ready=1 every cycle: all nine delivered in order, pointer wrap exercised, count never exceeds 1, no overflow.
- Three words queued with a handshake in progress, then clear high for one cycle: all outputs 0 next cycle. A subsequent push of 32'hB9800000 is delivered as the first word.
- With OUT_PORT_LAST_EN: after pushes 32'h1, 32'h2 and one pop, out_last=32'h2. After clear, out_last=0.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared CPU I/O definitions used by the output-port buffer and the future input-port buffer.
package cpu_io_pkg;

  localparam int WORD_W        = 32;
  localparam int OUT_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/io_fifo_mem.sv
// DEPTH x WIDTH register storage: one synchronous write port and one combinational read port.
module io_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage carries no reset; contents are meaningful only between the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/out_port_buffer.sv
// CPU output-port write buffer: queues OutPort_In words in a FIFO and hands them out over valid/ready.
// Optional feature: define OUT_PORT_LAST_EN to add the out_last debug view of the latest accepted word.
module out_port_buffer
  import cpu_io_pkg::*;
#(
  parameter int DEPTH = OUT_BUF_DEPTH,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     OutPort_In,
  input  logic [WIDTH-1:0]         BusMuxOut,
  output logic [WIDTH-1:0]         OutPortData,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   out_count,
`ifdef OUT_PORT_LAST_EN
  output logic [WIDTH-1:0]         out_last,
`endif
  output logic                     out_full,
  output logic                     out_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] rd_data;
  occ_state_t       occ;
  logic             push;
  logic             pop;

  always_comb begin
    occ = PARTIAL;
    if (count == '0) begin
      occ = EMPTY;
    end else if (count == DEPTH_C) begin
      occ = FULL;
    end
  end

  // A full queue still accepts a write when the head leaves on the same edge.
  assign pop  = out_valid && out_ready;
  assign push = OutPort_In && ((occ != FULL) || pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_full     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      out_full  <= (count_nxt == DEPTH_C);
      if (OutPort_In && !push) begin
        out_overflow <= 1'b1;
      end
    end
  end

  io_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (BusMuxOut),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign OutPortData = out_valid ? rd_data : '0;
  assign out_count   = count;

`ifdef OUT_PORT_LAST_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      out_last <= '0;
    end else if (push) begin
      out_last <= BusMuxOut;
    end
  end
`endif

endmodule

// File: tb/tb_out_port_buffer.sv
// Directed self-checking bench for out_port_buffer (DEPTH=4, WIDTH=32).
module tb_out_port_buffer;

  logic        clock = 1'b0;
  logic        clear;
  logic        OutPort_In;
  logic [31:0] BusMuxOut;
  logic [31:0] OutPortData;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_count;
  logic        out_full;
  logic        out_overflow;
`ifdef OUT_PORT_LAST_EN
  logic [31:0] out_last;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  out_port_buffer #(.DEPTH(4), .WIDTH(32)) dut (
    .clock        (clock),
    .clear        (clear),
    .OutPort_In   (OutPort_In),
    .BusMuxOut    (BusMuxOut),
    .OutPortData  (OutPortData),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
`ifdef OUT_PORT_LAST_EN
    .out_last     (out_last),
`endif
    .out_full     (out_full),
    .out_overflow (out_overflow)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; OutPort_In = 1'b0; out_ready = 1'b0; BusMuxOut = '0;
    tick();
    clear = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    OutPort_In = 1'b1; BusMuxOut = w;
    tick();
    OutPort_In = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    if (OutPortData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", OutPortData); end
    if (out_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", out_count); end
    if (out_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", out_full); end
    if (out_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", out_overflow); end
  endtask

  task automatic test_single();
    do_clear();
    push_word(32'h56781234);
    for (int i = 0; i < 4; i++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%0b exp=1", i, out_valid); end
      if (OutPortData !== 32'h56781234) begin failures++; $display("FAIL single_data[%0d] got=%h exp=56781234", i, OutPortData); end
      if (out_count !== 3'd1) begin failures++; $display("FAIL single_count[%0d] got=%0d exp=1", i, out_count); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained_valid got=%0b exp=0", out_valid); end
    if (OutPortData !== 32'h0) begin failures++; $display("FAIL single_drained_data got=%h exp=0", OutPortData); end
    // ready while empty must not disturb anything
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_count !== 3'd0) begin failures++; $display("FAIL empty_ready_count got=%0d exp=0", out_count); end
  endtask

  task automatic test_full_overflow();
    logic [31:0] exp_q [4];
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_clear();
    for (int i = 0; i < 4; i++) push_word(exp_q[i]);
    checks += 3;
    if (out_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0b exp=1", out_full); end
    if (out_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", out_count); end
    if (out_overflow !== 1'b0) begin failures++; $display("FAIL full_ovf_early got=%0b exp=0", out_overflow); end
    push_word(32'h55);
    checks += 3;
    if (out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", out_overflow); end
    if (out_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", out_count); end
    if (OutPortData !== 32'h11) begin failures++; $display("FAIL ovf_head got=%h exp=11", OutPortData); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (OutPortData !== exp_q[i] || out_valid !== 1'b1) begin
        failures++; $display("FAIL drain[%0d] got=%h v=%0b exp=%h", i, OutPortData, out_valid, exp_q[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_end_valid got=%0b exp=0", out_valid); end
    if (out_full !== 1'b0) begin failures++; $display("FAIL drain_end_full got=%0b exp=0", out_full); end
    if (out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", out_overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4];
    exp_q = '{32'h22, 32'h33, 32'h44, 32'hAA};
    do_clear();
    push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
    out_ready = 1'b1;
    push_word(32'hAA);
    checks += 4;
    if (out_count !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", out_count); end
    if (out_full !== 1'b1) begin failures++; $display("FAIL fpp_full got=%0b exp=1", out_full); end
    if (out_overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%0b exp=0", out_overflow); end
    if (OutPortData !== 32'h22) begin failures++; $display("FAIL fpp_head got=%h exp=22", OutPortData); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (OutPortData !== exp_q[i] || out_valid !== 1'b1) begin
        failures++; $display("FAIL fpp_drain[%0d] got=%h v=%0b exp=%h", i, OutPortData, out_valid, exp_q[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fpp_end_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      push_word(32'(i));
      checks += 2;
      if (OutPortData !== 32'(i) || out_valid !== 1'b1) begin
        failures++; $display("FAIL b2b_data[%0d] got=%h v=%0b exp=%h", i, OutPortData, out_valid, 32'(i));
      end
      if (out_count !== 3'd1) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=1", i, out_count); end
    end
    tick();
    out_ready = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%0b exp=0", out_valid); end
    if (out_count !== 3'd0) begin failures++; $display("FAIL b2b_end_count got=%0d exp=0", out_count); end
    if (out_overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%0b exp=0", out_overflow); end
  endtask

  task automatic test_clear_mid();
    do_clear();
    push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
    out_ready = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got=%0b exp=0", out_valid); end
    if (OutPortData !== 32'h0) begin failures++; $display("FAIL clr_data got=%h exp=0", OutPortData); end
    if (out_count !== 3'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", out_count); end
    if (out_full !== 1'b0 || out_overflow !== 1'b0) begin
      failures++; $display("FAIL clr_flags got=%0b%0b exp=00", out_full, out_overflow);
    end
    push_word(32'hB9800000);
    checks += 2;
    if (OutPortData !== 32'hB9800000 || out_valid !== 1'b1) begin
      failures++; $display("FAIL clr_first got=%h v=%0b exp=b9800000", OutPortData, out_valid);
    end
    if (out_count !== 3'd1) begin failures++; $display("FAIL clr_first_count got=%0d exp=1", out_count); end
  endtask

`ifdef OUT_PORT_LAST_EN
  task automatic test_last();
    do_clear();
    push_word(32'h1); push_word(32'h2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks += 2;
    if (out_last !== 32'h2) begin failures++; $display("FAIL last_val got=%h exp=2", out_last); end
    if (out_count !== 3'd1) begin failures++; $display("FAIL last_count got=%0d exp=1", out_count); end
    do_clear();
    checks++;
    if (out_last !== 32'h0) begin failures++; $display("FAIL last_clr got=%h exp=0", out_last); end
  endtask
`endif

  initial begin
    clear = 1'b0; OutPort_In = 1'b0; out_ready = 1'b0; BusMuxOut = '0;
    test_reset();
    test_single();
    test_full_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_clear_mid();
`ifdef OUT_PORT_LAST_EN
    test_last();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
